uart_frame_decoder: RTL
=======================

# uart_frame_decoder

Converts the raw byte stream from the UART receiver into fixed-length command frames for the command controller. A frame is an opcode byte, FRAME_LEN-2 payload bytes, and a terminator byte equal to the opcode. The block validates the terminator, presents the frame to the controller over a valid/ready handshake, and counts malformed frames. It sits between the UART receive path and the command dispatcher.

## Interface
Parameters:
- FRAME_LEN, 18: total frame length in bytes; legal values are 3 to 32.
- OPCODE_MIN, 64: lowest accepted opcode ("@").
- OPCODE_MAX, 67: highest accepted opcode ("C").
- TIMEOUT_CYCLES, 1033400: number of idle clocks inside a frame before the partial frame is abandoned (10 ms at 103.34 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- frame_valid  out  1  a complete, validated frame is on the frame_* outputs.
- frame_ready  in  1  the consumer accepts the frame.
- frame_op  out  8  opcode of the frame.
- frame_payload  out  8*(FRAME_LEN-2)  payload bytes. Payload byte k (k = 1 is the first byte after the opcode) is at bits [8k-1:8(k-1)].
- bad_frame_cnt  out  8  count of malformed frames; saturates at 255.
- overrun  out  1  one-cycle pulse for each byte dropped while a frame is pending.

## Operation
- State machine with three states: IDLE, COLLECT, HOLD.
- IDLE:
  - A byte with OPCODE_MIN ≤ rx_data ≤ OPCODE_MAX is latched into frame_op, idx is set to 1, and the state moves to COLLECT.
  - Any other byte is discarded silently and does not count as an error.
- COLLECT:
  - While idx ≤ FRAME_LEN-2, each byte is written to payload slot idx and idx increments.
  - When idx = FRAME_LEN-1, the byte is the terminator:
    - If it equals frame_op, the state moves to HOLD.
    - Otherwise bad_frame_cnt increments (saturating) and the state moves to IDLE. The payload register keeps its stale contents.
- HOLD:
  - frame_valid = 1. frame_op and frame_payload are stable.
  - In a cycle with frame_valid & frame_ready, the state moves to IDLE.
  - Every rx_valid byte in HOLD is dropped and pulses overrun, including a byte in the handshake cycle itself.
- idx is ceil(log2(FRAME_LEN)) bits wide and is never compared outside the range 1 to FRAME_LEN-1.
- Payload slots are overwritten in order. Slots are not cleared between frames.
- Reset values:
  - State IDLE; idx 0.
  - frame_valid 0, frame_op 0, frame_payload 0.
  - bad_frame_cnt 0, overrun 0.
- Assertion of reset_n low at any time, including mid-frame or in HOLD, forces these values immediately.

## Timing
- All outputs are registered.
- frame_valid rises in the cycle after the clock edge that samples a matching terminator. Latency from the terminator's rx_valid to frame_valid is 1 cycle.
- frame_valid falls in the cycle after a handshake. The earliest next opcode is accepted in the cycle after that, so bytes arriving in the handshake cycle are lost.
- bad_frame_cnt updates in the cycle after the sampled bad terminator or timeout.
- overrun is high in the cycle after the sampled dropped byte.
- rx_valid may be asserted every cycle; the block accepts one byte per cycle in IDLE and COLLECT.

## Configuration
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in COLLECT and clears to 0 on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid, the state moves to IDLE and bad_frame_cnt increments.
  - If rx_valid arrives in the expiry cycle, the byte wins: it is accepted and the counter clears.
  - The counter is held at 0 outside COLLECT.
- Undefined:
  - No counter logic is present.
  - COLLECT waits indefinitely for bytes.
  - bad_frame_cnt counts terminator mismatches only.

## Test plan
- Valid frame: feed "@", 'A', 15 × '?', "@" back to back → frame_valid rises 1 cycle after the last byte; frame_op = 0x40; payload[7:0] = 0x41; bad_frame_cnt = 0.
- Bad terminator: feed "B", 16 bytes, "C" → no frame_valid; bad_frame_cnt goes from 0 to 1; the next valid frame is decoded correctly.
- Filtering: send 0x00, 0x41 repeated across a valid "A…A" frame → stray non-opcode bytes before the opcode are ignored; one frame is produced.
- Backpressure: complete a frame with frame_ready = 0, then send 3 bytes → 3 overrun pulses; frame outputs unchanged; raising frame_ready gives frame_valid = 0 the next cycle.
- Timeout (FRAME_TIMEOUT_EN, TIMEOUT_CYCLES = 20): opcode plus 5 bytes, then 20 idle cycles → bad_frame_cnt = 1, state IDLE. Repeating with a byte in the expiry cycle → no timeout.
- Saturation and reset: 260 bad frames → bad_frame_cnt = 255. Pulling reset_n low mid-COLLECT → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
//   Turns the UART receive byte stream into fixed-length command frames.
//   A frame is: opcode byte, FRAME_LEN-2 payload bytes, terminator byte
//   equal to the opcode. Good frames are held on the frame_* outputs until
//   the consumer takes them (valid/ready). Frames with a wrong terminator
//   are dropped and counted.
//
//   Build option: define FRAME_TIMEOUT_EN to abandon a partial frame after
//   TIMEOUT_CYCLES idle clocks in COLLECT. An abandoned frame also counts
//   as malformed. Without the macro, COLLECT waits forever.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   rx_data[7:0]   received byte, qualified by rx_valid
//   rx_valid       one-cycle byte strobe
//   frame_valid    a validated frame is presented
//   frame_ready    consumer accepts the presented frame
//   frame_op       frame opcode
//   frame_payload  payload, byte k (k from 1) at [8k-1:8(k-1)]
//   bad_frame_cnt  malformed frame count, saturating at 255
//   overrun        one-cycle pulse per byte dropped while in HOLD
module uart_frame_decoder #(
  parameter int FRAME_LEN      = 18,
  parameter int OPCODE_MIN     = 64,
  parameter int OPCODE_MAX     = 67,
  parameter int TIMEOUT_CYCLES = 1033400
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [7:0]                 frame_op,
  output logic [8*(FRAME_LEN-2)-1:0] frame_payload,
  output logic [7:0]                 bad_frame_cnt,
  output logic                       overrun
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int PAY_N = FRAME_LEN - 2;
  // idx value at which the incoming byte is the terminator
  localparam logic [IDX_W-1:0] TERM_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       op_reg, op_next;
  logic [7:0]       bad_cnt_reg, bad_cnt_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             payload_we;
  logic             bad_event;
  logic             is_opcode;
  logic             tmo_expire;

  assign is_opcode = (rx_data >= 8'(OPCODE_MIN)) && (rx_data <= 8'(OPCODE_MAX));

`ifdef FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_reg, tmo_next;

  // Counts idle cycles in COLLECT only. An arriving byte always clears it,
  // so a byte in the expiry cycle wins over the timeout. Expiry also wraps
  // it to 0, matching the return to IDLE.
  always_comb begin
    tmo_next = '0;
    if (state_reg == COLLECT && !rx_valid && tmo_reg != TMO_LAST) begin
      tmo_next = tmo_reg + 1'b1;
    end
  end

  assign tmo_expire = (state_reg == COLLECT) && !rx_valid && (tmo_reg == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_next;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  // Next-state and datapath control
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    op_next      = op_reg;
    payload_we   = 1'b0;
    bad_event    = 1'b0;
    overrun_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Non-opcode bytes are line noise here, not errors.
        if (rx_valid && is_opcode) begin
          op_next    = rx_data;
          idx_next   = IDX_W'(1);
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          if (idx_reg == TERM_IDX) begin
            if (rx_data == op_reg) begin
              state_next = HOLD;
            end else begin
              bad_event  = 1'b1;
              state_next = IDLE;
            end
          end else begin
            payload_we = 1'b1;
            idx_next   = idx_reg + 1'b1;
          end
        end else if (tmo_expire) begin
          bad_event  = 1'b1;
          state_next = IDLE;
        end
      end
      HOLD: begin
        // Any byte here is lost, even one in the handshake cycle.
        overrun_next = rx_valid;
        if (valid_reg && frame_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    bad_cnt_next = bad_cnt_reg;
    if (bad_event && bad_cnt_reg != 8'hFF) begin
      bad_cnt_next = bad_cnt_reg + 8'd1;
    end

    valid_next = (state_next == HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      op_reg      <= 8'h00;
      bad_cnt_reg <= 8'h00;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      op_reg      <= op_next;
      bad_cnt_reg <= bad_cnt_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  // One register per payload slot; only the slot addressed by idx loads.
  // Slots are never cleared between frames, so a rejected frame leaves its
  // bytes visible on frame_payload.
  generate
    for (genvar gi = 0; gi < PAY_N; gi++) begin : g_slot
      logic [7:0] slot_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          slot_reg <= 8'h00;
        end else if (payload_we && idx_reg == IDX_W'(gi + 1)) begin
          slot_reg <= rx_data;
        end
      end

      assign frame_payload[8*gi +: 8] = slot_reg;
    end
  endgenerate

  assign frame_valid   = valid_reg;
  assign frame_op      = op_reg;
  assign bad_frame_cnt = bad_cnt_reg;
  assign overrun       = overrun_reg;

endmodule
